// File: rtl/rng_pool.sv
// rng_pool: TRNG entropy pool. Synchronised ring-oscillator bits are folded into a rule 90/150 CA
// and emitted over valid/ready after warm-up. Define RNG_HEALTH_EN to build the repetition-count health test.
module rng_pool #(
  parameter int              WIDTH       = 32,
  parameter int              NUM_SRC     = 32,
  parameter logic [WIDTH-1:0] RULE       = {{(WIDTH-1){1'b1}}, 1'b0},
  parameter int              SYNC_STAGES = 2,
  parameter int              WARMUP      = 64,
  parameter int              ACCUM       = 32,
  parameter int              REP_LIMIT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_SRC-1:0] source,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               alarm
);

  localparam int CNT_MAX = (WARMUP > ACCUM) ? WARMUP : ACCUM;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [CW-1:0] ACC_LAST  = CW'(ACCUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_ALARM} state_t;

  if (WIDTH < 4 || NUM_SRC < 1 || SYNC_STAGES < 2 || WARMUP < 1 || ACCUM < 1 || REP_LIMIT < 2) begin : g_bad_params
    $error("rng_pool: parameter out of range");
  end

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0]   pool_reg, pool_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic               valid_reg, valid_next;
  logic [NUM_SRC-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_SRC-1:0] syn;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH+1:0]   pool_pad;
  logic               health_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= source;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign syn = sync_reg[SYNC_STAGES-1];

  // Zero padding on both ends gives the null boundary for the edge cells.
  assign pool_pad = {1'b0, pool_reg, 1'b0};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic inj;
    always_comb begin
      inj = 1'b0;
      for (int i = gi; i < NUM_SRC; i += WIDTH) inj = inj ^ syn[i];
    end
    assign nxt[gi] = pool_pad[gi] ^ pool_pad[gi+2] ^ (RULE[gi] & pool_reg[gi]) ^ inj;
  end

  assign busy = (state_reg == S_WARMUP) || (state_reg == S_RUN);

`ifdef RNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

  logic [RW-1:0] rep_reg, rep_next;
  logic          last_h_reg;
  logic          h;

  assign h = ^syn;

  always_comb begin
    rep_next = RW'(1);
    if (h == last_h_reg) rep_next = (rep_reg == REP_MAX) ? REP_MAX : rep_reg + RW'(1);
  end

  assign health_fail = busy && (rep_next == REP_MAX);
  assign alarm       = (state_reg == S_ALARM);

  // Held clear while idle so every warm-up starts a fresh run count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_reg    <= '0;
      last_h_reg <= 1'b0;
    end else if (state_reg == S_IDLE) begin
      rep_reg    <= '0;
      last_h_reg <= 1'b0;
    end else begin
      rep_reg    <= rep_next;
      last_h_reg <= h;
    end
  end
`else
  assign health_fail = 1'b0;
  assign alarm       = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pool_next  = pool_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    case (state_reg)
      S_IDLE: begin
        if (en) begin
          state_next = S_WARMUP;
          cnt_next   = '0;
        end
      end
      S_WARMUP: begin
        pool_next = nxt;
        if (!en) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == WARM_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_RUN: begin
        pool_next = nxt;
        if (!en) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          valid_next = 1'b0;
        end else if (valid_reg) begin
          // Counter sits at zero while a word waits, so accumulation restarts on transfer.
          if (out_ready) valid_next = 1'b0;
        end else if (cnt_reg == ACC_LAST) begin
          data_next  = nxt;
          valid_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: ;
    endcase
    if (health_fail) begin
      state_next = S_ALARM;
      cnt_next   = '0;
      data_next  = data_reg;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      pool_reg  <= WIDTH'(1);
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pool_reg  <= pool_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_rng_pool.sv
// tb_rng_pool: scoreboard bench for rng_pool; a cycle-level reference model predicts each word and its edge.
`timescale 1ns/1ps
module tb_rng_pool;

  localparam int W  = 8;
  localparam int NS = 8;
  localparam int WU = 4;
  localparam int AC = 3;
  localparam int SS = 2;
  localparam int RL = 16;
  localparam logic [W-1:0] RULE_M = 8'hFE;
`ifdef RNG_HEALTH_EN
  localparam bit HEALTH_ON = 1'b1;
`else
  localparam bit HEALTH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          out_ready = 1'b1;
  logic [NS-1:0] source = '0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          busy;
  logic          alarm;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int src_mode = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  bit            m_active, m_valid, m_alarm, m_last;
  int            m_run, next_word_at;
  logic [W-1:0]  m_pool;
  logic [NS-1:0] syn_q[$];

  always #5 clk = ~clk;

  rng_pool #(
    .WIDTH(W), .NUM_SRC(NS), .RULE(RULE_M), .SYNC_STAGES(SS),
    .WARMUP(WU), .ACCUM(AC), .REP_LIMIT(RL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .source(source),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .alarm(alarm)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // One CA generation as whole-word arithmetic: neighbours via shifts, self term via the rule mask.
  function automatic logic [W-1:0] ca_step(logic [W-1:0] s, logic [NS-1:0] syn);
    logic [W-1:0] inj;
    inj = '0;
    for (int i = 0; i < NS; i++) inj[i % W] = inj[i % W] ^ syn[i];
    return (s << 1) ^ (s >> 1) ^ (s & RULE_M) ^ inj;
  endfunction

  function automatic void m_reset();
    m_active = 1'b0;
    m_valid  = 1'b0;
    m_alarm  = 1'b0;
    m_last   = 1'b0;
    m_run    = 0;
    m_pool   = W'(1);
    syn_q    = {};
    for (int i = 0; i < SS; i++) syn_q.push_back('0);
  endfunction

  function automatic void m_step();
    logic [NS-1:0] used;
    logic          h;
    used = syn_q.pop_front();
    syn_q.push_back(source);
    if (m_alarm) begin
    end else if (m_active) begin
      h      = ^used;
      m_run  = (h == m_last) ? ((m_run < RL) ? m_run + 1 : RL) : 1;
      m_last = h;
      m_pool = ca_step(m_pool, used);
      if (HEALTH_ON && m_run >= RL) begin
        m_alarm  = 1'b1;
        m_active = 1'b0;
        m_valid  = 1'b0;
      end else if (!en) begin
        m_active = 1'b0;
        m_valid  = 1'b0;
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid      = 1'b0;
          next_word_at = cyc + AC;
        end
      end else if (cyc == next_word_at) begin
        m_valid = 1'b1;
        exp_q.push_back('{cyc, m_pool});
      end
    end else if (en) begin
      m_active     = 1'b1;
      m_run        = 0;
      m_last       = 1'b0;
      next_word_at = cyc + WU + AC;
    end
  endfunction

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        cyc++;
        m_step();
      end
      #1;
      check("busy", busy, m_active);
      check("out_valid", out_valid, m_valid);
      check("alarm", alarm, m_alarm);
    end
  end

  initial begin : monitor
    bit           prev_valid;
    logic [W-1:0] held;
    exp_t         e;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("word_cycle", cyc, e.cyc);
          check("word_data", out_data, e.data);
          held = e.data;
        end
      end else if (out_valid) begin
        check("data_hold", out_data, held);
      end
      prev_valid = out_valid;
    end
  end

  initial begin : src_drv
    bit         tgl;
    logic [6:0] r;
    tgl = 1'b0;
    forever begin
      @(negedge clk);
      tgl = ~tgl;
      case (src_mode)
        0: source = '0;
        1: begin
          r      = 7'($urandom_range(0, 127));
          source = {(^r) ^ tgl, r};
        end
        default: source = {7'd0, tgl};
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, out_valid, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
  endtask

  initial begin : stim
    #2 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("init_out_data", out_data, '0);
    check("init_out_valid", out_valid, 1'b0);
    tick(2);

    // Timing and data: source stuck 0, ready high, words at +7, +11, +15
    src_mode  = 0;
    out_ready = 1'b1;
    en        = 1'b1;
    tick(16);
    do_reset();

    // Backpressure: hold a word for 100 cycles, then release once
    src_mode  = 1;
    out_ready = 1'b0;
    en        = 1'b1;
    wait_valid("bp_valid", 40);
    tick(100);
    out_ready = 1'b1;
    tick(10);

    // Reset while a word is pending
    out_ready = 1'b0;
    wait_valid("pre_rst_valid", 40);
    tick(3);
    do_reset();

    // en drop one cycle before the first word, then re-enable
    out_ready = 1'b1;
    en        = 1'b1;
    tick(WU + AC - 1);
    en = 1'b0;
    tick(6);
    en = 1'b1;
    tick(20);

    // Randomised ready / enable traffic
    for (int k = 0; k < 3000; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    do_reset();

    // Parity toggling every cycle: never a long repetition
    src_mode  = 2;
    out_ready = 1'b1;
    en        = 1'b1;
    tick(10000);
    do_reset();

    // Stuck source: alarm with health test, steady words without
    src_mode = 0;
    en       = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      out_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
    end
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(5);
    do_reset();
    tick(3);

    check("leftover_words", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rng_pool.md
Name: rng_pool

Overview:
Parametrised entropy pool for the cryptochip TRNG path. It takes NUM_SRC asynchronous ring-oscillator outputs, synchronises them, and folds them into a WIDTH-bit linear hybrid cellular automaton (rule 90/150 per cell). After a warm-up interval it emits conditioned words over a valid/ready handshake. A continuous health test on the raw source stream can latch a sticky alarm.

Parameters:
- WIDTH, 32: pool/output word width (>=4).
- NUM_SRC, 32: number of raw entropy source bits (>=1).
- RULE, {WIDTH{1'b1}} ^ 1: per-cell rule mask; bit i=1 selects rule 150 for cell i, 0 selects rule 90.
- SYNC_STAGES, 2: synchroniser depth per source bit (>=2).
- WARMUP, 64: cycles in WARMUP before any output (>=1).
- ACCUM, 32: cycles of mixing between emitted words (>=1).
- REP_LIMIT, 16: consecutive identical health samples that trigger the alarm (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable; level-sensitive.
- source  in  NUM_SRC  raw ring-oscillator outputs, asynchronous to clk.
- out_data  out  WIDTH  random word; stable while out_valid=1.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word; transfer occurs on out_valid&out_ready at a clk edge.
- busy  out  1  high in WARMUP or RUN.
- alarm  out  1  sticky health-test failure flag.

Behaviour:
- Reset (async, rst=1):
  - Every synchroniser flop = 0; pool state = 1 (bit0=1, all others 0).
  - Counters = 0; FSM = IDLE.
  - out_data=0, out_valid=0, busy=0, alarm=0.
- Synchroniser: each source bit passes through SYNC_STAGES flops. syn = last-stage vector.
- Fold: inj[j] = XOR of syn[i] over all i with i mod WIDTH == j. A cell with no contributing source gets inj=0.
- Pool update: nxt[i] = s[i-1] ^ s[i+1] ^ (RULE[i] & s[i]) ^ inj[i].
  - Null boundary: s[-1] = s[WIDTH] = 0.
  - The update runs every cycle in WARMUP and RUN.
  - The pool holds in IDLE and ALARM.
- FSM states IDLE, WARMUP, RUN, ALARM:
  - IDLE: en=1 -> WARMUP, with the counter loaded to 0.
  - WARMUP: the counter increments each cycle. When counter==WARMUP-1 -> RUN, with the counter cleared.
  - RUN: the counter increments while out_valid=0.
    - When counter==ACCUM-1: out_data <= nxt, out_valid <= 1, counter <= 0.
    - While out_valid=1 the counter holds and out_data is frozen; the pool keeps mixing.
    - On transfer: out_valid <= 0 and accumulation restarts. The next word is valid ACCUM cycles after the transfer edge.
  - First out_valid rises on the edge WARMUP+ACCUM cycles after the first edge sampling en=1.
  - en=0 in WARMUP or RUN -> IDLE next edge:
    - out_valid <= 0; any pending word is discarded.
    - Counter cleared; pool state retained.
  - Health failure in any state except IDLE -> ALARM. Health failure takes priority over en=0 and over a same-cycle transfer; the transfer does not occur.
  - ALARM: out_valid=0, alarm=1, busy=0. The block leaves ALARM only on rst; en is ignored.
- busy = (state==WARMUP || state==RUN).
- Health test (repetition count):
  - Health sample h = XOR-reduce(syn), evaluated every cycle outside IDLE.
  - run counter: reset to 1 on a new value of h, +1 on a repeated value, saturating at REP_LIMIT.
  - Reaching REP_LIMIT -> ALARM.
  - The counter and the last value of h clear on entering WARMUP.
- out_ready with out_valid=0 has no effect.
- With out_ready held high, words transfer exactly every ACCUM+1 cycles.

Optional Feature:
- Macro: RNG_HEALTH_EN.
- Defined: repetition-count health test, ALARM state and alarm output behave as above.
- Undefined: no health logic is synthesised; alarm is tied 0 and ALARM is unreachable. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-RUN with out_valid=1 -> all outputs 0 immediately (asynchronous); after release, pool=1 and FSM=IDLE.
- Timing and data (WIDTH=8, NUM_SRC=8, WARMUP=4, ACCUM=3, health off):
  - Stimulus: source=8'h00, out_ready=1, en rises at edge 0.
  - First out_valid at edge 7; words every 4 cycles.
  - out_data matches a rule-90/150 software model seeded with 8'h01.
- Backpressure: hold out_ready=0 for 100 cycles after out_valid -> out_data stable and out_valid high throughout; raising out_ready transfers once, then out_valid=0 for 3 cycles.
- en drop: deassert en one cycle before the first word -> out_valid never rises; busy=0 next edge; re-enable -> full WARMUP+ACCUM delay again.
- Health (RNG_HEALTH_EN, REP_LIMIT=16):
  - source stuck 0 -> alarm=1 and out_valid=0 after 16 samples; stays set despite en toggling until rst.
  - source[0] toggling each cycle -> alarm stays 0 for 10000 cycles.
- Health compiled out: source stuck 0 for 1000 cycles -> alarm=0 and words keep flowing.
